// File: rtl/signal_sync_pipe.sv
// signal_sync_pipe: LATENCY-stage pipeline returning input_data + INCR, with an occupancy counter.
// Latency LATENCY cycles plus one per stall cycle; stall is global while output valid && !resp_ready.
// Optional macro SIGNAL_SYNC_PIPE_SAT_EN: saturating add, resp_overflow travels with the data.
module signal_sync_pipe #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      LATENCY = 2,
    parameter logic [WIDTH-1:0] INCR    = WIDTH'(1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           request,
    input  logic [WIDTH-1:0]               input_data,
    output logic                           req_ready,
    output logic [WIDTH-1:0]               final_resp,
    output logic                           final_resp_valid,
    input  logic                           resp_ready,
    output logic                           resp_overflow,
    output logic [$clog2(LATENCY+1)-1:0]   in_flight
);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    logic [LATENCY-1:0][WIDTH-1:0] data_q, data_d;
    logic [LATENCY-1:0]            vld_q, vld_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          stall, accept, depart;
    logic [WIDTH-1:0]              s1_dat;

    assign stall  = vld_q[LATENCY-1] && !resp_ready;
    assign accept = request && !stall;
    assign depart = vld_q[LATENCY-1] && resp_ready;

`ifdef SIGNAL_SYNC_PIPE_SAT_EN
    logic [LATENCY-1:0] ovf_q, ovf_d;
    logic [WIDTH:0]     sum;
    logic               s1_ovf;

    // The extra carry bit only decides saturation; it never reaches the data path.
    assign sum    = {1'b0, input_data} + {1'b0, INCR};
    assign s1_ovf = sum[WIDTH];
    assign s1_dat = s1_ovf ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

    always_comb begin
        ovf_d = ovf_q;
        if (!stall) begin
            if (request) begin
                ovf_d[0] = s1_ovf;
            end
            for (int i = 1; i < LATENCY; i++) begin
                ovf_d[i] = ovf_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign resp_overflow = ovf_q[LATENCY-1];
`else
    assign s1_dat        = input_data + INCR;
    assign resp_overflow = 1'b0;
`endif

    // Bubbles are not collapsed: every stage advances together so latency stays fixed.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (!stall) begin
            vld_d[0] = request;
            if (request) begin
                data_d[0] = s1_dat;
            end
            for (int i = 1; i < LATENCY; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            cnt_d = cnt_q + CW'(accept) - CW'(depart);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign req_ready        = !stall;
    assign final_resp       = data_q[LATENCY-1];
    assign final_resp_valid = vld_q[LATENCY-1];
    assign in_flight        = cnt_q;

endmodule

// File: doc/signal_sync_pipe.md
# signal_sync_pipe

Parametrised increment-response pipeline, the successor to the single-stage request/response block used in the signal-asynchrony studies. Each accepted request carries `input_data`; exactly `LATENCY` cycles later the block presents `input_data + INCR` with a valid flag that is cycle-aligned with that data. Output-side backpressure stalls the whole pipeline, and an occupancy counter is exported for protocol checking.

## Interface
- `WIDTH`, 32: data width in bits, ≥1.
- `LATENCY`, 2: pipeline depth in stages, ≥1; also the request-to-response latency in cycles when there is no stall.
- `INCR`, 1: constant added to each request, `WIDTH` bits, unsigned.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `request` in 1: request valid.
- `input_data` in `WIDTH`: request payload; sampled only on an accepted request.
- `req_ready` out 1: block can accept a request this cycle (combinational).
- `final_resp` out `WIDTH`: response data.
- `final_resp_valid` out 1: `final_resp` is valid this cycle.
- `resp_ready` in 1: consumer accepts the response this cycle.
- `resp_overflow` out 1: the response saturated. Driven only with the configuration macro; tied 0 without it.
- `in_flight` out `$clog2(LATENCY+1)`: number of valid stages currently occupied, 0..`LATENCY`.

## Operation
- `LATENCY` stages. Each stage holds a data register and a valid bit. Stage `LATENCY` drives `final_resp`, `final_resp_valid` and `resp_overflow`.
- `stall = final_resp_valid && !resp_ready`. `req_ready = !stall`.
- Accept: `request && req_ready`. Stage 1 loads `input_data + INCR`, and its valid bit is set.
- A cycle with `!request` while not stalled loads a bubble into stage 1: valid=0, data unchanged.
- When not stalled, every stage i>1 loads stage i-1, including valid, data and the overflow bit.
- When stalled, every stage holds, including its valid bits. A request presented during a stall is not captured, and no state changes.
- The pipeline does not collapse bubbles; the stall is global. This is deliberate, because it keeps latency deterministic.
- Arithmetic: the sum is taken modulo 2^`WIDTH` (wrap) unless the configuration macro is defined. The carry out of the adder is used only for overflow detection.
- `in_flight` counts the set valid bits. It is maintained as a counter and is updated each non-stalled cycle by (+1 if accept) and (−1 if stage `LATENCY` valid departs). It is never negative and never exceeds `LATENCY`.
- A response departs when `final_resp_valid && resp_ready`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - all valid bits clear
  - all data registers go to 0
  - `final_resp` = 0, `final_resp_valid` = 0, `resp_overflow` = 0, `in_flight` = 0
  - `req_ready` = 1 (because no stall)
- Reset asserted mid-operation discards every in-flight request immediately, without waiting for a clock edge.
- Latency: a request accepted in cycle c produces `final_resp_valid`=1 with its result in cycle c+`LATENCY`, plus one cycle for each stall cycle in between.
- Data and valid come from the same stage register, so they are never misaligned.
- While stalled, `final_resp` and `resp_overflow` are stable until the response departs.
- Back-to-back accepts (`request` held high, `resp_ready` high) give one response per cycle, in order, with no gaps.
- Simultaneous accept and departure in one cycle: `in_flight` is unchanged.
- A full pipeline (`in_flight` = `LATENCY`) with `resp_ready` high still accepts; the block's throughput is one request per cycle.
- `resp_ready` low while `final_resp_valid` is 0 does not stall.

## Configuration
- `SIGNAL_SYNC_PIPE_SAT_EN` defined:
  - the stage-1 add saturates at 2^`WIDTH`−1 when the true sum exceeds it
  - `resp_overflow` is carried down the pipeline with the data and is asserted aligned with the saturated response
- Not defined:
  - the add wraps modulo 2^`WIDTH`
  - `resp_overflow` is constant 0, and no overflow flops are instantiated

## Test plan
- Reset with defaults, then assert `request` with `input_data`=5 in cycle 1, `resp_ready`=1:
  - `final_resp_valid`=1 with `final_resp`=6 in cycle 3 only
  - `in_flight` = 1 in cycles 2–3
- Back-to-back: requests 10, 20, 30 in consecutive cycles:
  - responses 11, 21, 31 in 3 consecutive cycles, starting 2 cycles after the first request
  - valid is never high with stale data
- Backpressure:
  - `resp_ready`=0 for 3 cycles while response 11 is valid → `final_resp` holds 11, `req_ready`=0, and a request of 99 presented during the stall is dropped
  - after release, responses resume in order
- Boundary add: `input_data`=32'hFFFFFFFF:
  - without the macro → 32'h00000000, `resp_overflow`=0
  - with `SIGNAL_SYNC_PIPE_SAT_EN` → 32'hFFFFFFFF, `resp_overflow`=1
- Reset mid-flight: `LATENCY`=4, two requests in flight, then pull `rst_n` low between edges → all outputs 0 and `in_flight`=0 immediately, and no stale response appears after release.
- `LATENCY`=1, `WIDTH`=8, `INCR`=3: request of 8'd254 → `final_resp`=8'd1 (wrap) the next cycle.
